// File: rtl/game_pieces_renderer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : game_pieces_pkg
// Purpose  : Shared types and constants for the game-pieces LED renderer.
//            Holds the cell and winner encodings, the matrix size, and the
//            scan FSM states.
// Ports    : none (package)
// Revision : 1.0 - initial parametrised release
// ============================================================================
package game_pieces_pkg;

  localparam int MATRIX_DIM = 16;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'b00,
    CELL_P1    = 2'b01,
    CELL_P2    = 2'b10,
    CELL_RSVD  = 2'b11
  } cell_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } fsm_state_t;

endpackage

`default_nettype wire

// File: rtl/game_pieces_renderer_win_detect.sv
`default_nettype none
// ============================================================================
// Module   : game_win_detect
// Purpose  : Combinational win/draw detection over an N x N board snapshot.
//            Checks every row, column and both diagonals; P1 wins take
//            priority over P2 wins, and a full board without a win is a draw.
// Ports    : cells_i    - board snapshot, index = row*BOARD_N+col
//            winner_o   - WIN_NONE / WIN_P1 / WIN_P2 / WIN_DRAW
//            win_mask_o - union of every completed line (one bit per cell)
// Revision : 1.0 - initial parametrised release
// ============================================================================
module game_win_detect
  import game_pieces_pkg::*;
#(
  parameter int BOARD_N = 3
) (
  input  logic [BOARD_N*BOARD_N-1:0][1:0] cells_i,
  output winner_t                         winner_o,
  output logic [BOARD_N*BOARD_N-1:0]      win_mask_o
);

  localparam int NCELL = BOARD_N * BOARD_N;
  localparam int NLINE = 2 * BOARD_N + 2;
  localparam int IDX_W = $clog2(NCELL);

  // Lines 0..N-1 are rows, N..2N-1 are columns, 2N is the main diagonal and
  // 2N+1 the anti-diagonal; k walks along the line.
  function automatic logic [IDX_W-1:0] line_cell(input int l, input int k);
    int n;
    if (l < BOARD_N)           n = l * BOARD_N + k;
    else if (l < 2 * BOARD_N)  n = k * BOARD_N + (l - BOARD_N);
    else if (l == 2 * BOARD_N) n = k * BOARD_N + k;
    else                       n = k * BOARD_N + (BOARD_N - 1 - k);
    return IDX_W'(n);
  endfunction

  logic             p1_any, p2_any, full, all_p1, all_p2;
  logic [NCELL-1:0] mask_p1, mask_p2;

  always_comb begin
    p1_any  = 1'b0;
    p2_any  = 1'b0;
    full    = 1'b1;
    all_p1  = 1'b0;
    all_p2  = 1'b0;
    mask_p1 = '0;
    mask_p2 = '0;
    for (int c = 0; c < NCELL; c++) begin
      if (cells_i[IDX_W'(c)] != CELL_P1 && cells_i[IDX_W'(c)] != CELL_P2) full = 1'b0;
    end
    for (int l = 0; l < NLINE; l++) begin
      all_p1 = 1'b1;
      all_p2 = 1'b1;
      for (int k = 0; k < BOARD_N; k++) begin
        if (cells_i[line_cell(l, k)] != CELL_P1) all_p1 = 1'b0;
        if (cells_i[line_cell(l, k)] != CELL_P2) all_p2 = 1'b0;
      end
      for (int k = 0; k < BOARD_N; k++) begin
        if (all_p1) mask_p1[line_cell(l, k)] = 1'b1;
        if (all_p2) mask_p2[line_cell(l, k)] = 1'b1;
      end
      if (all_p1) p1_any = 1'b1;
      if (all_p2) p2_any = 1'b1;
    end
  end

  assign win_mask_o = mask_p1 | mask_p2;
  assign winner_o   = p1_any ? WIN_P1 :
                      p2_any ? WIN_P2 :
                      full   ? WIN_DRAW : WIN_NONE;

endmodule

`default_nettype wire

// File: rtl/game_pieces_renderer.sv
`default_nettype none
// ============================================================================
// Module   : game_pieces_renderer
// Purpose  : Renders an N x N board of 2-bit cells as X (red) / O (green)
//            glyphs, optional amber grid lines and a blinking winning line
//            into double-buffered 16x16 LED planes. A scan draws one cell per
//            cycle into the back buffers, then commits them in one edge.
// Ports    : clk       - system clock
//            reset     - synchronous, active-low reset
//            cells     - cell states, index = row*BOARD_N+col
//            grid_en   - draw grid lines when 1
//            RedPixels - red plane [row][col], row 0 = top
//            GrnPixels - green plane [row][col]
//            winner    - 00 none, 01 P1, 10 P2, 11 draw
//            busy      - high while scanning or committing
// Revision : 1.0 - initial parametrised release
// ============================================================================
module game_pieces_renderer
  import game_pieces_pkg::*;
#(
  parameter int BOARD_N      = 3,
  parameter int CELL_PX      = 4,
  parameter int GAP_PX       = 1,
  parameter int ORIGIN       = 1,
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [BOARD_N*BOARD_N-1:0][1:0]       cells,
  input  logic                                  grid_en,
  output logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0] RedPixels,
  output logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0] GrnPixels,
  output logic [1:0]                            winner,
  output logic                                  busy
);

  localparam int NCELL   = BOARD_N * BOARD_N;
  localparam int PITCH   = CELL_PX + GAP_PX;
  localparam int EXTENT  = BOARD_N * CELL_PX + (BOARD_N - 1) * GAP_PX;
  localparam int IDX_W   = $clog2(NCELL);
  localparam int PIX_W   = $clog2(MATRIX_DIM);
  localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);

  typedef logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0] plane_t;

  if (ORIGIN + EXTENT > MATRIX_DIM || CELL_PX < 3) begin : g_param_check
    $error("game_pieces_renderer: board does not fit the matrix or CELL_PX < 3");
  end

  fsm_state_t                    state_q;
  logic [IDX_W-1:0]              idx_q;
  logic [NCELL-1:0][1:0]         snap_cells_q;
  logic                          snap_grid_q;
  logic                          pending_q;
  logic [BLINK_W-1:0]            blink_cnt_q;
  logic                          phase_q;
  plane_t                        red_back_q, grn_back_q;
  plane_t                        red_back_d, grn_back_d;
  plane_t                        red_out_q, grn_out_q;
  logic [1:0]                    winner_q;
  logic                          busy_q;

  winner_t                       snap_winner;
  logic [NCELL-1:0]              win_mask;
  plane_t                        grid_mask, glyph_x, glyph_o;
  int                            row_base, col_base;
  logic [1:0]                    cell_code;
  logic                          cell_visible;
  logic                          blink_wrap;

  game_win_detect #(
    .BOARD_N(BOARD_N)
  ) u_win_detect (
    .cells_i   (snap_cells_q),
    .winner_o  (snap_winner),
    .win_mask_o(win_mask)
  );

  // Gap rows/columns between cells, clipped to the board extent.
  always_comb begin
    grid_mask = '0;
    for (int g = 0; g < BOARD_N - 1; g++) begin
      for (int k = 0; k < GAP_PX; k++) begin
        for (int t = 0; t < EXTENT; t++) begin
          grid_mask[PIX_W'(ORIGIN + g * PITCH + CELL_PX + k)][PIX_W'(ORIGIN + t)] = 1'b1;
          grid_mask[PIX_W'(ORIGIN + t)][PIX_W'(ORIGIN + g * PITCH + CELL_PX + k)] = 1'b1;
        end
      end
    end
  end

  // X and O glyph masks placed at the cell currently being scanned.
  always_comb begin
    glyph_x  = '0;
    glyph_o  = '0;
    row_base = ORIGIN + (int'(idx_q) / BOARD_N) * PITCH;
    col_base = ORIGIN + (int'(idx_q) % BOARD_N) * PITCH;
    for (int i = 0; i < CELL_PX; i++) begin
      for (int j = 0; j < CELL_PX; j++) begin
        if (i == j || i + j == CELL_PX - 1)
          glyph_x[PIX_W'(row_base + i)][PIX_W'(col_base + j)] = 1'b1;
        // Border pixel on exactly one edge axis: the ring minus its corners.
        if ((i == 0 || i == CELL_PX - 1) != (j == 0 || j == CELL_PX - 1))
          glyph_o[PIX_W'(row_base + i)][PIX_W'(col_base + j)] = 1'b1;
      end
    end
  end

  // Winning-line cells are hidden during the off half of the blink; a draw
  // never blinks because it has no winning line.
  assign cell_code    = snap_cells_q[idx_q];
  assign cell_visible = !(win_mask[idx_q] && !phase_q &&
                          (snap_winner == WIN_P1 || snap_winner == WIN_P2));
  assign red_back_d   = red_back_q | ((cell_code == CELL_P1 && cell_visible) ? glyph_x : '0);
  assign grn_back_d   = grn_back_q | ((cell_code == CELL_P2 && cell_visible) ? glyph_o : '0);
  assign blink_wrap   = (blink_cnt_q == BLINK_W'(BLINK_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      snap_cells_q <= '0;
      snap_grid_q  <= 1'b0;
      pending_q    <= 1'b1;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      red_back_q   <= '0;
      grn_back_q   <= '0;
      red_out_q    <= '0;
      grn_out_q    <= '0;
      winner_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      if (blink_wrap) begin
        blink_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
      end

      case (state_q)
        IDLE: begin
          if (cells != snap_cells_q || grid_en != snap_grid_q || pending_q) begin
            snap_cells_q <= cells;
            snap_grid_q  <= grid_en;
            pending_q    <= 1'b0;
            red_back_q   <= grid_en ? grid_mask : '0;
            grn_back_q   <= grid_en ? grid_mask : '0;
            idx_q        <= '0;
            busy_q       <= 1'b1;
            state_q      <= SCAN;
          end
        end
        SCAN: begin
          red_back_q <= red_back_d;
          grn_back_q <= grn_back_d;
          if (idx_q == IDX_W'(NCELL - 1)) state_q <= COMMIT;
          else                            idx_q   <= idx_q + IDX_W'(1);
        end
        COMMIT: begin
          red_out_q <= red_back_q;
          grn_out_q <= grn_back_q;
          winner_q  <= snap_winner;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // A blink edge forces a redraw; it must win over IDLE clearing pending.
      if (blink_wrap) pending_q <= 1'b1;
    end
  end

  assign RedPixels = red_out_q;
  assign GrnPixels = grn_out_q;
  assign winner    = winner_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire
